// File: rtl/pacer_pkg.sv
// Shared constants and timestamp helpers for the departure pacer.
package pacer_pkg;

   localparam int TS_WIDTH        = 32;
   localparam int TUSER_MAX_WIDTH = 1024;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BODY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Caller zero-extends tuser to TUSER_MAX_WIDTH; a shift avoids a wide variable index.
   function automatic logic [TS_WIDTH-1:0] ts_extract(input logic [TUSER_MAX_WIDTH-1:0] tuser,
                                                      input int unsigned              pos);
      logic [TUSER_MAX_WIDTH-1:0] sh;
      sh = tuser >> pos;
      return sh[TS_WIDTH-1:0];
   endfunction

   // Wrap-safe distance now-target; valid while the true distance is below 2^31.
   function automatic logic signed [TS_WIDTH-1:0] ts_diff(input logic [TS_WIDTH-1:0] now,
                                                          input logic [TS_WIDTH-1:0] target);
      return signed'(now - target);
   endfunction

endpackage

// File: rtl/pacer_gap_counter.sv
// Inter-packet idle-gap down-counter: load N, done pulses on the Nth cycle after load.
// Free-running once loaded; ignores downstream backpressure.
module pacer_gap_counter #(
   parameter int C_GAP_WIDTH = 16
) (
   input  logic                   axi_aclk,
   input  logic                   axi_reset,
   input  logic                   load,
   input  logic [C_GAP_WIDTH-1:0] load_val,
   output logic                   done
);

   logic [C_GAP_WIDTH-1:0] cnt;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - C_GAP_WIDTH'(1);
   end

   assign done = (cnt == C_GAP_WIDTH'(1));

endmodule

// File: rtl/pkt_departure_pacer.sv
// Releases each packet's header once time_now reaches tuser timestamp + offset, then enforces a min idle gap.
// Zero-latency pass-through; backpressure passes straight through, tvalid never retracts once shown.
module pkt_departure_pacer
   import pacer_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH     = 256,
   parameter int C_AXIS_TUSER_WIDTH    = 128,
   parameter int C_TUSER_TIMESTAMP_POS = 32,
   parameter int C_GAP_WIDTH           = 16
) (
   input  logic                            axi_aclk,
   input  logic                            axi_reset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   input  logic [TS_WIDTH-1:0]             time_now,
   input  logic                            cfg_ts_en,
   input  logic [TS_WIDTH-1:0]             cfg_ts_offset,
   input  logic [C_GAP_WIDTH-1:0]          cfg_min_gap,
   output logic [31:0]                     stat_pkt_count,
   output logic [31:0]                     stat_late_count
);

   logic [1:0]                 state, state_nxt;
   logic                       hold;
   logic                       pass_en, hs, eop, gap_load, gap_done;
   logic                       due, late;
   logic [TUSER_MAX_WIDTH-1:0] tuser_ext;
   logic [TS_WIDTH-1:0]        target;
   logic signed [TS_WIDTH-1:0] diff;

   assign tuser_ext = TUSER_MAX_WIDTH'(s_axis_tuser);
   assign target    = ts_extract(tuser_ext, C_TUSER_TIMESTAMP_POS) + cfg_ts_offset;
   assign diff      = ts_diff(time_now, target);
   // A target over 2^31 ahead aliases to "past": released at once and counted late.
   assign due       = !cfg_ts_en || !diff[TS_WIDTH-1];
   assign late      = cfg_ts_en && !diff[TS_WIDTH-1] && (diff != '0);

   always_comb begin
      pass_en = 1'b0;
      if (!axi_reset) begin
         case (state)
            ST_IDLE: pass_en = due | hold;
            ST_BODY: pass_en = 1'b1;
            default: pass_en = 1'b0;
         endcase
      end
   end

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tstrb  = s_axis_tstrb;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = s_axis_tvalid & pass_en;
   assign s_axis_tready = m_axis_tready & pass_en;
   assign hs            = s_axis_tvalid & m_axis_tready & pass_en;

   always_comb begin
      state_nxt = state;
      eop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hs) begin
               if (s_axis_tlast)
                  eop = 1'b1;
               else
                  state_nxt = ST_BODY;
            end
         end
         ST_BODY: if (hs && s_axis_tlast) eop = 1'b1;
         ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (eop)
         state_nxt = (cfg_min_gap == '0) ? ST_IDLE : ST_GAP;
   end

   assign gap_load = eop && (cfg_min_gap != '0);

   pacer_gap_counter #(
      .C_GAP_WIDTH (C_GAP_WIDTH)
   ) u_gap (
      .axi_aclk  (axi_aclk),
      .axi_reset (axi_reset),
      .load      (gap_load),
      .load_val  (cfg_min_gap),
      .done      (gap_done)
   );

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state           <= ST_IDLE;
         hold            <= 1'b0;
         stat_pkt_count  <= '0;
         stat_late_count <= '0;
      end else begin
         state <= state_nxt;
         // Once a header is visible it stays visible, whatever happens to time or cfg.
         if (hs)
            hold <= 1'b0;
         else if (state == ST_IDLE && m_axis_tvalid)
            hold <= 1'b1;
         if (eop)
            stat_pkt_count <= stat_pkt_count + 32'd1;
         if (hs && state == ST_IDLE && late)
            stat_late_count <= stat_late_count + 32'd1;
      end
   end

endmodule
